// File: rtl/bb_clk_ratio_mon.sv
// Divided-clock monitor: measures div_clk period and high width in i_clk cycles,
// locks after LOCK_CNT equal periods, flags period changes and missing edges.
module bb_clk_ratio_mon #(
    parameter int RATIO_WID   = 8,
    parameter int LOCK_CNT    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 div_clk,
    input  logic [RATIO_WID-1:0] exp_ratio,
    output logic [RATIO_WID-1:0] meas_ratio,
    output logic [RATIO_WID-1:0] meas_high,
    output logic                 rise_pulse,
    output logic                 locked,
    output logic                 ratio_ok,
    output logic                 mismatch,
    output logic                 timeout
);
    typedef enum logic [1:0] {IDLE, ACQ, MEAS, LOCKED} state_t;

    localparam logic [RATIO_WID-1:0] CNT_MAX    = '1;
    localparam logic [RATIO_WID-1:0] ONE        = RATIO_WID'(1);
    localparam logic [3:0]           LOCK_MATCH = 4'(LOCK_CNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s, s_d_q, rise, fall;
    state_t                 state_q, state_d;
    logic [RATIO_WID-1:0]   cnt_q, cnt_d, hcnt_q, hcnt_d;
    logic [RATIO_WID-1:0]   meas_ratio_q, meas_ratio_d, meas_high_q, meas_high_d;
    logic [3:0]             match_q, match_d, match_inc;
    logic                   locked_q, locked_d, rise_q, rise_d;
    logic                   mismatch_q, mismatch_d, timeout_q, timeout_d;

    // Sampling chain keeps running while disabled so enabling never fakes an edge.
    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q[0] <= div_clk;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_d_q <= s;
        end
    end

    assign s         = sync_q[SYNC_STAGES-1];
    assign rise      = s & ~s_d_q;
    assign fall      = ~s & s_d_q;
    assign match_inc = (match_q == 4'hF) ? match_q : match_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hcnt_d       = hcnt_q;
        meas_ratio_d = meas_ratio_q;
        meas_high_d  = meas_high_q;
        match_d      = match_q;
        locked_d     = locked_q;
        rise_d       = en & rise;
        mismatch_d   = 1'b0;
        timeout_d    = 1'b0;
        if (!en) begin
            state_d      = IDLE;
            cnt_d        = '0;
            hcnt_d       = '0;
            meas_ratio_d = '0;
            meas_high_d  = '0;
            match_d      = '0;
            locked_d     = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = ACQ;
        end else if (rise) begin
            cnt_d  = ONE;
            hcnt_d = ONE;
            if (state_q == ACQ) begin
                // First edge only starts a period; nothing to report yet.
                state_d = MEAS;
                match_d = '0;
            end else begin
                meas_ratio_d = cnt_q;
                if (cnt_q == meas_ratio_q) begin
                    match_d = match_inc;
                    if (state_q == MEAS && match_inc == LOCK_MATCH) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end else begin
                    match_d = 4'd1;
                    if (state_q == LOCKED) begin
                        mismatch_d = 1'b1;
                        locked_d   = 1'b0;
                        state_d    = MEAS;
                    end
                end
            end
        end else if (cnt_q == CNT_MAX) begin
            timeout_d    = 1'b1;
            state_d      = ACQ;
            cnt_d        = '0;
            hcnt_d       = '0;
            meas_ratio_d = '0;
            meas_high_d  = '0;
            match_d      = '0;
            locked_d     = 1'b0;
        end else begin
            cnt_d = cnt_q + ONE;
            if (s) begin
                hcnt_d = hcnt_q + ONE;
            end
            if (fall && (state_q == MEAS || state_q == LOCKED)) begin
                meas_high_d = hcnt_q;
            end
        end
    end

    always_ff @(posedge i_clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            hcnt_q       <= '0;
            meas_ratio_q <= '0;
            meas_high_q  <= '0;
            match_q      <= '0;
            locked_q     <= 1'b0;
            rise_q       <= 1'b0;
            mismatch_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hcnt_q       <= hcnt_d;
            meas_ratio_q <= meas_ratio_d;
            meas_high_q  <= meas_high_d;
            match_q      <= match_d;
            locked_q     <= locked_d;
            rise_q       <= rise_d;
            mismatch_q   <= mismatch_d;
            timeout_q    <= timeout_d;
        end
    end

    assign meas_ratio = meas_ratio_q;
    assign meas_high  = meas_high_q;
    assign rise_pulse = rise_q;
    assign locked     = locked_q;
    assign mismatch   = mismatch_q;
    assign timeout    = timeout_q;
    assign ratio_ok   = locked_q && (meas_ratio_q == exp_ratio);
endmodule

// File: tb/tb_bb_clk_ratio_mon.sv
// Bench for bb_clk_ratio_mon: event-level reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized tail.
module tb_bb_clk_ratio_mon;
    localparam int NS   = 2;
    localparam int LC   = 4;
    localparam int MAXC = 255;
    localparam int M_IDLE = 0, M_ACQ = 1, M_MEAS = 2, M_LOCK = 3;

    logic       i_clk = 1'b0;
    logic       rst, en, div_clk;
    logic [7:0] exp_ratio;
    logic [7:0] meas_ratio, meas_high;
    logic       rise_pulse, locked, ratio_ok, mismatch, timeout;

    bb_clk_ratio_mon #(.RATIO_WID(8), .LOCK_CNT(LC), .SYNC_STAGES(NS)) dut (
        .i_clk(i_clk), .rst(rst), .en(en), .div_clk(div_clk), .exp_ratio(exp_ratio),
        .meas_ratio(meas_ratio), .meas_high(meas_high), .rise_pulse(rise_pulse),
        .locked(locked), .ratio_ok(ratio_ok), .mismatch(mismatch), .timeout(timeout)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge i_clk) cyc++;

    // Reference model: tracks the age of the current period, the length of
    // the run of equal periods, and the high samples of the current period.
    int m_mode, age, high, run, m_ratio, m_high;
    bit m_rise, m_lock, m_mis, m_to, ms, msd;
    bit smp[$];

    always @(posedge i_clk or posedge rst) begin
        if (rst) begin
            m_mode = M_IDLE; age = 0; high = 0; run = 0; m_ratio = 0; m_high = 0;
            m_rise = 0; m_lock = 0; m_mis = 0; m_to = 0;
            smp = {};
            for (int i = 0; i <= NS; i++) smp.push_back(1'b0);
        end else begin
            ms  = smp[NS-1];
            msd = smp[NS];
            smp.push_front(div_clk);
            void'(smp.pop_back());
            m_rise = en && ms && !msd;
            m_mis = 0;
            m_to  = 0;
            if (!en) begin
                m_mode = M_IDLE; age = 0; high = 0; run = 0; m_ratio = 0; m_high = 0; m_lock = 0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_ACQ;
            end else if (ms && !msd) begin
                if (m_mode == M_ACQ) begin
                    m_mode = M_MEAS;
                    run = 0;
                end else begin
                    if (age == m_ratio) run = (run < 15) ? run + 1 : 15;
                    else begin
                        run = 1;
                        if (m_mode == M_LOCK) begin m_mis = 1; m_lock = 0; m_mode = M_MEAS; end
                    end
                    if (m_mode == M_MEAS && run == LC) begin m_mode = M_LOCK; m_lock = 1; end
                    m_ratio = age;
                end
                age = 1;
                high = 1;
            end else if (age == MAXC) begin
                m_to = 1; m_mode = M_ACQ; age = 0; high = 0; run = 0;
                m_ratio = 0; m_high = 0; m_lock = 0;
            end else begin
                age++;
                if (!ms && msd && m_mode >= M_MEAS) m_high = high;
                if (ms) high++;
            end
        end
    end

    always @(negedge i_clk) begin
        if (!rst && chk_on) begin
            check("meas_ratio", meas_ratio, m_ratio);
            check("meas_high", meas_high, m_high);
            check("rise_pulse", rise_pulse, m_rise);
            check("locked", locked, m_lock);
            check("mismatch", mismatch, m_mis);
            check("timeout", timeout, m_to);
            check("ratio_ok", ratio_ok, int'(m_lock && (m_ratio == exp_ratio)));
        end
    end

    // Event log of DUT pulses used by the directed literal checks.
    int rise_cnt = 0, last_rise_cyc = 0, mis_cnt = 0, mis_rise = 0;
    int to_cnt = 0, to_cyc = 0, lock_rise = 0;
    bit lock_prev = 1'b0;
    always @(negedge i_clk) begin
        if (rise_pulse) begin rise_cnt++; last_rise_cyc = cyc; end
        if (mismatch) begin mis_cnt++; mis_rise = rise_cnt; end
        if (timeout) begin to_cnt++; to_cyc = cyc; end
        if (locked && !lock_prev) lock_rise = rise_cnt;
        lock_prev = locked;
    end

    task automatic periods(input int h, input int l, input int n);
        for (int k = 0; k < n; k++) begin
            div_clk = 1'b1;
            repeat (h) @(negedge i_clk);
            div_clk = 1'b0;
            repeat (l) @(negedge i_clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_meas_ratio"}, meas_ratio, 0);
        check({tag, "_meas_high"}, meas_high, 0);
        check({tag, "_rise_pulse"}, rise_pulse, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_ratio_ok"}, ratio_ok, 0);
        check({tag, "_mismatch"}, mismatch, 0);
        check({tag, "_timeout"}, timeout, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int base, tbase;
    initial begin
        rst = 1'b0; en = 1'b0; div_clk = 1'b0; exp_ratio = 8'd0;
        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        repeat (3) @(negedge i_clk);
        rst = 1'b0;
        chk_on = 1'b1;

        // Period 4, 2 high / 2 low: lock on the rise ending the 4th period.
        exp_ratio = 8'd4;
        base = rise_cnt;
        en = 1'b1;
        periods(2, 2, 6);
        check("t2_meas_ratio", meas_ratio, 4);
        check("t2_meas_high", meas_high, 2);
        check("t2_locked", locked, 1);
        check("t2_ratio_ok", ratio_ok, 1);
        check("t2_lock_rise_idx", lock_rise - base, LC + 1);
        exp_ratio = 8'd5;
        #1;
        check("t2_ratio_ok_exp5", ratio_ok, 0);
        check("t2_locked_exp5", locked, 1);

        // Switch to period 6: single mismatch, relock after 4 periods of 6.
        exp_ratio = 8'd6;
        base = mis_cnt;
        periods(3, 3, 5);
        check("t3_mismatch_cnt", mis_cnt - base, 1);
        check("t3_relock_dist", lock_rise - mis_rise, LC - 1);
        check("t3_meas_ratio", meas_ratio, 6);
        check("t3_locked", locked, 1);

        // Asynchronous reset while locked.
        @(posedge i_clk);
        #2 rst = 1'b1;
        #1 check_all_zero("t1_async_rst");
        @(negedge i_clk);
        @(negedge i_clk);
        rst = 1'b0;

        // Relock at 4, then stop div_clk: one timeout 255 cycles after the last rise.
        exp_ratio = 8'd4;
        periods(2, 2, 6);
        check("t4_relock", locked, 1);
        tbase = to_cnt;
        repeat (300) @(negedge i_clk);
        check("t4_timeout_cnt", to_cnt - tbase, 1);
        check("t4_timeout_dist", to_cyc - last_rise_cyc, 255);
        check("t4_meas_ratio", meas_ratio, 0);
        check("t4_locked", locked, 0);
        periods(2, 2, 6);
        check("t4_resume_lock", locked, 1);

        // Longest measurable period locks; one cycle longer times out.
        exp_ratio = 8'd255;
        tbase = to_cnt;
        periods(128, 127, 6);
        check("t5_meas_ratio", meas_ratio, 255);
        check("t5_meas_high", meas_high, 128);
        check("t5_locked", locked, 1);
        check("t5_ratio_ok", ratio_ok, 1);
        check("t5_no_timeout", to_cnt - tbase, 0);
        periods(128, 128, 3);
        check("t5_timeout_seen", int'(to_cnt - tbase >= 2), 1);
        check("t5_unlocked", locked, 0);

        // Drop en in MEAS, re-enable: the first rise only restarts acquisition.
        exp_ratio = 8'd6;
        periods(3, 3, 3);
        check("t6_in_meas", locked, 0);
        en = 1'b0;
        @(negedge i_clk);
        check_all_zero("t6_en_off");
        en = 1'b1;
        base = rise_cnt;
        periods(3, 3, 1);
        check("t6_first_rise", rise_cnt - base, 1);
        check("t6_no_update", meas_ratio, 0);
        periods(3, 3, 1);
        check("t6_second_rise", meas_ratio, 6);

        // Randomized period changes, exp_ratio changes and enable blips.
        for (int it = 0; it < 14; it++) begin
            int h, l, n;
            h = $urandom_range(1, 5);
            l = $urandom_range(1, 5);
            n = $urandom_range(3, 9);
            exp_ratio = 8'($urandom_range(2, 10));
            periods(h, l, n);
            if ($urandom_range(0, 3) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge i_clk);
                en = 1'b1;
            end
        end
        periods(2, 3, 6);
        check("rand_final_lock", locked, 1);
        check("rand_final_ratio", meas_ratio, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
